// File: rtl/minmax_window.sv
// minmax_window: window controller and result stage for a minmax2 min/max tree
// Cuts the sample stream into win_len-cycle windows by pulsing the tree's reset,
// captures the tree's xmin/xmax after each window has drained through tree_lat
// register levels, and offers min, max, span, alarm and sequence number on a
// valid/ready port.
// Parameters: dw sample width, tree_lat tree register levels above the leaves,
//             lw width of win_len.
// Ports:
//   clk, reset                            clock, synchronous active-high reset
//   enable                                run windows back-to-back while high
//   win_len                               window length in cycles (0 and 1 act as 2)
//   thresh                                unsigned span alarm threshold
//   mm_clear                              window clear, drives the tree's reset
//   xmin, xmax                            tree outputs
//   r_valid, r_ready                      result handshake
//   r_min, r_max, r_span, r_alarm, r_seq  result fields
//   overrun                               sticky, set when a result is dropped
// Optional: define MINMAX_WINDOW_ALARM_HOLD_EN to add alarm_clr (in) and
//           alarm_hold (out), a sticky flag set by every computed alarm.
module minmax_window #(
    parameter int dw = 16,
    parameter int tree_lat = 2,
    parameter int lw = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [lw-1:0]        win_len,
    input  logic [dw:0]          thresh,
    output logic                 mm_clear,
    input  logic signed [dw-1:0] xmin,
    input  logic signed [dw-1:0] xmax,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic signed [dw-1:0] r_min,
    output logic signed [dw-1:0] r_max,
    output logic [dw:0]          r_span,
    output logic                 r_alarm,
    output logic [7:0]           r_seq,
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
    input  logic                 alarm_clr,
    output logic                 alarm_hold,
`endif
    output logic                 overrun
);
    localparam logic [0:0] s_idle = 1'b0;
    localparam logic [0:0] s_run = 1'b1;
    logic [0:0] state;
    logic [lw-1:0] len, cnt, len_next;
    logic win_end;
    // bit 0 is the end tag, bit tree_lat is the tag once the tree has settled
    logic [tree_lat:0] tag_sr;
    logic cap_v;
    logic signed [dw-1:0] cap_min, cap_max;
    logic [dw:0] span;
    logic alarm;
    logic [7:0] seq, seq_next;
    logic load;
    always_comb begin
        len_next = (win_len < lw'(2)) ? lw'(2) : win_len;
        win_end = (state == s_run) && (cnt == len - lw'(1));
        // sign-extend both operands so max - min never wraps
        span = {cap_max[dw-1], cap_max} - {cap_min[dw-1], cap_min};
        alarm = span > thresh;
        seq_next = seq + 8'd1;
        load = cap_v && (!r_valid || r_ready);
    end
    // window sequencer: cnt is the cycle index inside the window, c0 clears the tree
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_idle;
            mm_clear <= 1'b1;
            cnt <= '0;
            len <= lw'(2);
            tag_sr <= '0;
        end else begin
            tag_sr <= (tag_sr << 1) | (tree_lat + 1)'(win_end);
            if (state == s_idle || win_end) begin
                state <= enable ? s_run : s_idle;
                mm_clear <= 1'b1;
                cnt <= '0;
                if (enable) len <= len_next;
            end else begin
                mm_clear <= 1'b0;
                cnt <= cnt + lw'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_v <= 1'b0;
            cap_min <= '0;
            cap_max <= '0;
        end else begin
            cap_v <= tag_sr[tree_lat];
            if (tag_sr[tree_lat]) begin
                cap_min <= xmin;
                cap_max <= xmax;
            end
        end
    end
    // a result that cannot load is dropped but still consumes a sequence number
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_min <= '0;
            r_max <= '0;
            r_span <= '0;
            r_alarm <= 1'b0;
            r_seq <= '0;
            seq <= '0;
            overrun <= 1'b0;
        end else begin
            if (cap_v) seq <= seq_next;
            if (load) begin
                r_valid <= 1'b1;
                r_min <= cap_min;
                r_max <= cap_max;
                r_span <= span;
                r_alarm <= alarm;
                r_seq <= seq_next;
            end else if (r_ready) begin
                r_valid <= 1'b0;
            end
            if (cap_v && r_valid && !r_ready) overrun <= 1'b1;
        end
    end
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
    // a new alarm outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) alarm_hold <= 1'b0;
        else if (cap_v && alarm) alarm_hold <= 1'b1;
        else if (alarm_clr) alarm_hold <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_minmax_window.sv
// tb_minmax_window: scoreboard bench for minmax_window driven by a 4-leaf, 2-level min/max tree model
module tb_minmax_window;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic r_ready = 1'b1;
    logic [15:0] win_len = 16'd8;
    logic [16:0] thresh = 17'd1500;
    logic mm_clear, r_valid, r_alarm, overrun;
    logic signed [15:0] xmin, xmax, r_min, r_max;
    logic [16:0] r_span;
    logic [7:0] r_seq;
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
    logic alarm_clr = 1'b0;
    logic alarm_hold;
`endif
    logic signed [15:0] x [4];
    logic signed [15:0] xd [4];
    logic signed [15:0] amin [4];
    logic signed [15:0] amax [4];
    logic signed [15:0] lmin [2];
    logic signed [15:0] lmax [2];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int base;
    typedef struct {int mn; int mx; int sp; int al; int sq; int cy;} exp_t;
    exp_t q[$];

    minmax_window #(.dw(16), .tree_lat(2), .lw(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .win_len(win_len), .thresh(thresh),
        .mm_clear(mm_clear), .xmin(xmin), .xmax(xmax), .r_valid(r_valid), .r_ready(r_ready),
        .r_min(r_min), .r_max(r_max), .r_span(r_span), .r_alarm(r_alarm), .r_seq(r_seq),
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
        .alarm_clr(alarm_clr), .alarm_hold(alarm_hold),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tree model: leaves register their input, accumulate, and restart on mm_clear
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            xd[i] <= x[i];
            amin[i] <= (mm_clear || xd[i] < amin[i]) ? xd[i] : amin[i];
            amax[i] <= (mm_clear || xd[i] > amax[i]) ? xd[i] : amax[i];
        end
        for (int i = 0; i < 2; i++) begin
            lmin[i] <= (amin[2*i] < amin[2*i+1]) ? amin[2*i] : amin[2*i+1];
            lmax[i] <= (amax[2*i] > amax[2*i+1]) ? amax[2*i] : amax[2*i+1];
        end
        xmin <= (lmin[0] < lmin[1]) ? lmin[0] : lmin[1];
        xmax <= (lmax[0] > lmax[1]) ? lmax[0] : lmax[1];
    end

    function automatic void chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x[0] = 16'(a);
        x[1] = 16'(b);
        x[2] = 16'(c);
        x[3] = 16'(d);
    endtask

    task automatic push(input int mn, input int mx, input int sp, input int al, input int sq, input int cy);
        exp_t e;
        e.mn = mn;
        e.mx = mx;
        e.sp = sp;
        e.al = al;
        e.sq = sq;
        e.cy = cy;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain", q.size(), 0);
    endtask

    // monitor: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (r_valid === 1'b1 && r_ready) begin
            chk("result expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("r_min", r_min, e.mn);
                chk("r_max", r_max, e.mx);
                chk("r_span", r_span, e.sp);
                chk("r_alarm", r_alarm, e.al);
                chk("r_seq", r_seq, e.sq);
                if (e.cy >= 0) chk("r_valid cycle", cyc, e.cy);
            end
        end
    end

    // one L=8 window; lo enters at c(-1), hi at c(L-2); values at c(-2) and c(L-1) must be excluded
    task automatic single(input int lo, input int hi, input int thr, input int sp, input int al,
                          input int sq, input int clr_k);
        thresh = 17'(thr);
        win_len = 16'd8;
        enable = 1'b0;
        set_x(5000, -5000, 0, 0);
        tick();
        base = cyc;
        push(lo, hi, sp, al, sq, base + 13);
        for (int k = -1; k < 18; k++) begin
            enable = k < 3;
            if (k == -1) set_x(lo, 0, 0, 0);
            else if (k <= 5) set_x(100, 200, -50, 7);
            else if (k == 6) set_x(0, 0, hi, 0);
            else if (k == 7) set_x(-9000, 9000, 0, 0);
            else set_x(0, 0, 0, 0);
            if (k == 0) chk("c0 mm_clear", mm_clear, 1);
            if (k == 1) chk("c1 mm_clear", mm_clear, 0);
            if (k == 7) chk("c7 mm_clear", mm_clear, 0);
            if (k == 8) chk("idle mm_clear", mm_clear, 1);
            if (k == 15) chk("idle mm_clear late", mm_clear, 1);
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
            alarm_clr = (k == clr_k);
            if (clr_k >= 0 && k == clr_k + 1) chk("alarm_hold set beats clr", alarm_hold, 1);
`endif
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        set_x(0, 0, 0, 0);
        reset = 1'b1;
        repeat (5) tick();
        chk("reset r_valid", r_valid, 0);
        chk("reset r_min", r_min, 0);
        chk("reset r_max", r_max, 0);
        chk("reset r_span", r_span, 0);
        chk("reset r_alarm", r_alarm, 0);
        chk("reset r_seq", r_seq, 0);
        chk("reset overrun", overrun, 0);
        chk("reset mm_clear", mm_clear, 1);
        reset = 1'b0;
        repeat (2) tick();
        single(-300, 1200, 1500, 1500, 0, 1, -9);
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
        chk("alarm_hold quiet", alarm_hold, 0);
`endif
        single(-300, 1200, 1499, 1500, 1, 2, -9);
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
        chk("alarm_hold set", alarm_hold, 1);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        chk("alarm_hold cleared", alarm_hold, 0);
`endif
        single(-32768, 32767, 1500, 65535, 1, 3, 11);
        drain();

        // continuous L=4 with a stalled reader across two loads
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset r_seq again", r_seq, 0);
        tick();
        win_len = 16'd4;
        thresh = 17'd500;
        base = cyc;
        for (int w = 0; w < 7; w++)
            if (w != 3) push(-10 * (w + 1), 100 * (w + 1), 110 * (w + 1), (110 * (w + 1) > 500) ? 1 : 0,
                             w + 1, (w == 2) ? base + 21 : base + 9 + 4 * w);
        for (int j = -1; j < 36; j++) begin
            enable = j < 26;
            r_ready = !(j >= 16 && j <= 19);
            set_x(((j + 1) % 4 == 0 && j < 27) ? -10 * ((j + 1) / 4 + 1) : 0, 0, 0,
                  (j % 4 == 2 && j < 27) ? 100 * ((j - 2) / 4 + 1) : 0);
            if (j == 4) chk("b2b c0 mm_clear", mm_clear, 1);
            if (j == 5) chk("b2b c1 mm_clear", mm_clear, 0);
            if (j == 19) chk("overrun before drop", overrun, 0);
            if (j == 20) chk("overrun after drop", overrun, 1);
            tick();
        end
        drain();

        // minimum length: win_len 1 then 0 both act as 2
        win_len = 16'd1;
        base = cyc;
        for (int w = 0; w < 4; w++) push(-(w + 1), w + 1, 2 * (w + 1), 0, 8 + w, base + 7 + 2 * w);
        for (int j = -1; j < 16; j++) begin
            enable = j < 7;
            if (j == 0) win_len = 16'd0;
            set_x((j % 2 != 0 && j < 7) ? -((j + 1) / 2 + 1) : 0, 0, 0,
                  (j % 2 == 0 && j >= 0 && j < 7) ? j / 2 + 1 : 0);
            if (j == 1) chk("L2 c1 mm_clear", mm_clear, 0);
            if (j == 2) chk("L2 next c0 mm_clear", mm_clear, 1);
            tick();
        end
        drain();

        // win_len 8 -> 4 mid-window: current window stays 8, next is 4
        win_len = 16'd8;
        base = cyc;
        push(-7, 70, 77, 0, 12, base + 13);
        push(-4, 40, 44, 0, 13, base + 17);
        for (int j = -1; j < 20; j++) begin
            enable = j < 10;
            if (j == 3) win_len = 16'd4;
            set_x(j == -1 ? -7 : (j == 7 ? -4 : 0), 0, 0, j == 6 ? 70 : (j == 10 ? 40 : 0));
            if (j == 4) chk("len change c4 mm_clear", mm_clear, 0);
            if (j == 8) chk("len change c8 mm_clear", mm_clear, 1);
            if (j == 9) chk("short window c1 mm_clear", mm_clear, 0);
            if (j == 12) chk("after short window mm_clear", mm_clear, 1);
            tick();
        end
        drain();

        // reset in c5 of an L=8 window: no result, everything back to reset values
        win_len = 16'd8;
        for (int j = -1; j < 24; j++) begin
            enable = j < 5;
            reset = (j == 5);
            set_x(j == -1 ? -20 : 0, 0, 0, j == 2 ? 20 : 0);
            if (j == 4) chk("pre-reset mm_clear", mm_clear, 0);
            if (j == 6) begin
                chk("mid reset r_valid", r_valid, 0);
                chk("mid reset r_min", r_min, 0);
                chk("mid reset r_max", r_max, 0);
                chk("mid reset r_span", r_span, 0);
                chk("mid reset r_alarm", r_alarm, 0);
                chk("mid reset r_seq", r_seq, 0);
                chk("mid reset overrun", overrun, 0);
                chk("mid reset mm_clear", mm_clear, 1);
`ifdef MINMAX_WINDOW_ALARM_HOLD_EN
                chk("mid reset alarm_hold", alarm_hold, 0);
`endif
            end
            if (j == 14) chk("post reset mm_clear", mm_clear, 1);
            tick();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/minmax_window.md
# minmax_window

Window controller and result stage directly downstream of the `minmax2` min/max tree.
- Generates the tree's `reset` (window clear) pulses to cut the sample stream into fixed-length windows.
- Captures the tree's `xmin`/`xmax` once each window has propagated through the tree, and computes peak-to-peak span and a threshold alarm.
- Presents one result per window on a valid/ready port to the register/readout layer.

## Interface
- `dw`, 16: sample width; must match the tree.
- `tree_lat`, 2: register levels above the tree leaves, ceil(log2 n); 2 for n=4, 0 for n=1.
- `lw`, 16: width of the window-length input.
- `clk`  in  1: clock; everything is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: run windows back-to-back while high.
- `win_len`  in  lw: window length in clk cycles; values 0 and 1 are treated as 2.
- `thresh`  in  dw+1: unsigned span alarm threshold.
- `mm_clear`  out  1: drives the tree's `reset`.
- `xmin`, `xmax`  in  dw signed: tree outputs.
- `r_valid`  out  1; `r_ready`  in  1: result handshake.
- `r_min`, `r_max`  out  dw signed: captured extremes.
- `r_span`  out  dw+1 unsigned: `r_max - r_min`.
- `r_alarm`  out  1: `r_span > thresh`.
- `r_seq`  out  8: window sequence number.
- `overrun`  out  1: sticky; set when a result is dropped.

## Operation
- **States**
  - IDLE: `mm_clear`=1 continuously.
  - RUN: `mm_clear`=0 except in the first cycle of each window.
- **IDLE → RUN**: when `enable`=1.
  - Latch the clamped `win_len` into the length register L.
  - The entry cycle is window cycle c0; `mm_clear`=1 in c0.
- **RUN**
  - A counter runs c1..c(L-1) with `mm_clear`=0.
  - At the end of c(L-1) the window ends and an end tag is issued.
  - If `enable`=1: the next window starts at once. L is re-latched from `win_len`, and its c0 (`mm_clear`=1) is the cycle after c(L-1).
  - If `enable`=0: go to IDLE.
  - `win_len` changes and `enable` deassertion never shorten a window in progress.
- **Capture**
  - The end tag is delayed through a `tree_lat`-deep shift register.
  - When it emerges, register `xmin`/`xmax`.
  - The following edge computes `span = xmax - xmin` in dw+1 bits. This never wraps for any signed dw operands.
  - Compute `alarm = span > thresh` (unsigned) on the same edge.
  - Increment the internal sequence count, and offer the result to the output register.
- **Output handshake**
  - An offered result loads when `r_valid`=0, or when `r_valid`=1 and `r_ready`=1 in the same cycle. Back-to-back results are lossless in that case.
  - If `r_valid`=1 and `r_ready`=0, the new result is dropped. `overrun` is set and the sequence count still advances, so a gap in `r_seq` marks the loss.
  - `r_valid` clears on `r_valid & r_ready` when nothing is loading that cycle.
- **Reset**
  - Returns to IDLE with `mm_clear`=1.
  - Clears the counter, the delay line (pending captures are discarded), and the result stage.
  - Values after reset: `r_valid`=0, `r_min`=`r_max`=0, `r_span`=0, `r_alarm`=0, `r_seq`=0, `overrun`=0.
  - Reset mid-window emits no result for that window.

## Timing
- Window covering cycles c0..c(L-1): the tree output is final during cycle c(L+tree_lat). It is captured at the end of that cycle.
- `r_valid` rises in cycle c(L+tree_lat+2).
- Result period equals L cycles for continuous windows.
- Samples are referred to the tree leaf's internal delayed input. The window covers leaf inputs presented in cycles c(-1)..c(L-2).
- `mm_clear` is a registered output.
- Minimum L=2 yields one result every 2 cycles.

## Configuration
- Macro: `MINMAX_WINDOW_ALARM_HOLD_EN`.
- **Defined**
  - Adds output `alarm_hold` (1) and input `alarm_clr` (1).
  - `alarm_hold` sets on any computed alarm, including from dropped results.
  - It is cleared by `reset` or `alarm_clr`; a set in the same cycle wins.
- **Undefined**: both ports and the logic are absent; all other behaviour is identical.

## Test plan
Bench instantiates the block with a `minmax2` tree (dw=16, n=4, tree_lat=2), `r_ready`=1 unless stated.
- **Single window**: L=8; window samples include -300 and +1200; `enable` held for exactly one window.
  - Expect `r_min`=-300, `r_max`=1200, `r_span`=1500.
  - Expect `r_valid` in c12, `r_seq`=1, then IDLE.
- **Alarm**: `thresh`=1500 with span 1500 → `r_alarm`=0; `thresh`=1499 → `r_alarm`=1.
- **Extremes**: samples -32768 and 32767 → `r_span`=65535, no wrap.
- **Back-to-back and overrun**: continuous L=4.
  - `r_valid` pulses every 4 cycles with `r_seq` 1, 2, 3…
  - `r_ready`=0 across two result loads → `overrun`=1 and the next `r_seq` skips by 2.
- **Mid-operation change and reset**
  - `win_len` changed 8→4 mid-window → the current window stays 8, the next is 4.
  - `reset` in c5 → no result emitted, all outputs at reset values, `mm_clear`=1.
- **Macro build**: alarm then `alarm_clr` → `alarm_hold` 1 then 0; an alarm and `alarm_clr` in the same cycle → 1.
